// File: rtl/lab2_pkg.sv
// Shared definitions for the lab2_4 block and its built-in self-test controller.
package lab2_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Reference output of lab2_4 for x = 7..0 (bit index = x).
    localparam logic [7:0] TRUTH_TABLE = 8'b00111001;

    localparam logic [3:0] FAIL_SAT = 4'd15;

    // Increment that holds at the saturation value instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        return (value == FAIL_SAT) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/bist_vec_gen.sv
// Vector sequencer for the BIST: holds each of the eight input vectors for
// DWELL cycles, repeats the 0..7 sweep PASSES times, and flags the sample
// cycles (the last dwell cycle of each vector) plus the final sample.
module bist_vec_gen #(
    parameter int DWELL  = 2,
    parameter int PASSES = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    output logic [2:0] vec,
    output logic       sample_stb,
    output logic       last_sample
);

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);
    localparam logic [3:0] PASS_LAST  = 4'(PASSES - 1);

    logic [3:0] dwell_cnt;
    logic [3:0] pass_cnt;

    assign sample_stb  = enable && (dwell_cnt == DWELL_LAST);
    assign last_sample = sample_stb && (vec == 3'd7) && (pass_cnt == PASS_LAST);

    // Advance dwell, vector and pass counters while the test owns the block.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vec       <= 3'd0;
            dwell_cnt <= 4'd0;
            pass_cnt  <= 4'd0;
        end else if (clear) begin
            vec       <= 3'd0;
            dwell_cnt <= 4'd0;
            pass_cnt  <= 4'd0;
        end else if (enable) begin
            if (sample_stb) begin
                dwell_cnt <= 4'd0;
                vec       <= vec + 3'd1;
                if (vec == 3'd7) begin
                    pass_cnt <= pass_cnt + 4'd1;
                end
            end else begin
                dwell_cnt <= dwell_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/lab2_4_bist_ctrl.sv
// BIST controller for lab2_4: arbitrates the block input between the
// functional requester and the vector sweep, and collects failure results.
module lab2_4_bist_ctrl
    import lab2_pkg::*;
#(
    parameter int DWELL  = 2,
    parameter int PASSES = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] func_x,
    output logic [2:0] dut_x,
    input  logic       dut_error,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_count,
    output logic [2:0] first_fail_vec,
    output logic       first_fail_valid
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [2:0] vec;
    logic       sample_stb;
    logic       last_sample;
    logic       accept;
    logic       running;
    logic       fail_hit;
    logic [3:0] fail_count_next;

    assign accept   = (state == ST_IDLE) && start && !abort;
    assign running  = (state == ST_RUN) && !abort;
    assign fail_hit = running && sample_stb && dut_error;

    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);
    assign dut_x = busy ? vec : func_x;

    bist_vec_gen #(
        .DWELL  (DWELL),
        .PASSES (PASSES)
    ) u_vec_gen (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (accept),
        .enable      (busy),
        .vec         (vec),
        .sample_stb  (sample_stb),
        .last_sample (last_sample)
    );

    // Next-state decode; abort dominates both start and completion.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start && !abort) state_next = ST_RUN;
            ST_RUN: begin
                if (abort)            state_next = ST_IDLE;
                else if (last_sample) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Failure count including the sample taken this cycle.
    always_comb begin
        fail_count_next = fail_count;
        if (fail_hit) fail_count_next = sat_inc(fail_count);
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Result registers; the verdict is taken on the edge into DONE so it is
    // already valid during the done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pass             <= 1'b0;
            fail_count       <= 4'd0;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
        end else if (accept) begin
            pass             <= 1'b0;
            fail_count       <= 4'd0;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
        end else begin
            fail_count <= fail_count_next;
            if (fail_hit && !first_fail_valid) begin
                first_fail_vec   <= vec;
                first_fail_valid <= 1'b1;
            end
            if (running && last_sample) begin
                pass <= (fail_count_next == 4'd0);
            end
        end
    end

endmodule

// File: tb/tb_lab2_4_bist_ctrl.sv
// Directed bench for lab2_4_bist_ctrl: one instance with DWELL=2/PASSES=1,
// one with DWELL=1/PASSES=2 fed by a stuck-at-1 error flag.
module tb_lab2_4_bist_ctrl;
    import lab2_pkg::*;

    logic       clock;
    logic       reset_n;

    logic       start1, abort1, dut_error1;
    logic [2:0] func_x1, dut_x1;
    logic       busy1, done1, pass1, ffv1;
    logic [3:0] fail_count1;
    logic [2:0] ffvec1;

    logic       start2, abort2, dut_error2;
    logic [2:0] func_x2, dut_x2;
    logic       busy2, done2, pass2, ffv2;
    logic [3:0] fail_count2;
    logic [2:0] ffvec2;

    logic [7:0] good_tt;
    logic [7:0] bad_tt1;
    logic       stuck2;

    int checks = 0;
    int errors = 0;
    logic seen_done;

    // Behavioural lab2_4 pair: error flags where the faulty copy differs.
    assign good_tt    = TRUTH_TABLE;
    assign dut_error1 = good_tt[dut_x1] ^ bad_tt1[dut_x1];
    assign dut_error2 = stuck2;

    lab2_4_bist_ctrl #(.DWELL(2), .PASSES(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .start(start1), .abort(abort1),
        .func_x(func_x1), .dut_x(dut_x1), .dut_error(dut_error1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_count(fail_count1),
        .first_fail_vec(ffvec1), .first_fail_valid(ffv1)
    );

    lab2_4_bist_ctrl #(.DWELL(1), .PASSES(2)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .start(start2), .abort(abort2),
        .func_x(func_x2), .dut_x(dut_x2), .dut_error(dut_error2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_count(fail_count2),
        .first_fail_vec(ffvec2), .first_fail_valid(ffv2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic ab, input logic [2:0] fx);
        start1  = st;
        abort1  = ab;
        func_x1 = fx;
    endtask

    // Move to 1 time unit after the next rising edge (start of a new cycle).
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'b011);
        start2 = 1'b0; abort2 = 1'b0; func_x2 = 3'b101; stuck2 = 1'b0;
        bad_tt1 = TRUTH_TABLE;

        // Reset values
        #2;
        checkOutput("rst_busy", 8'(busy1), 8'h0);
        checkOutput("rst_done", 8'(done1), 8'h0);
        checkOutput("rst_pass", 8'(pass1), 8'h0);
        checkOutput("rst_fail_count", 8'(fail_count1), 8'h0);
        checkOutput("rst_ffvec", 8'(ffvec1), 8'h0);
        checkOutput("rst_ffv", 8'(ffv1), 8'h0);
        checkOutput("rst_dut_x", 8'(dut_x1), 8'h3);
        tick(); tick();
        reset_n = 1'b1;

        // Healthy sweep, with a second start pulsed mid-run
        $display("[TB] healthy sweep");
        applyStimulus(1'b1, 1'b0, 3'b010);
        tick();
        for (int c = 1; c <= 16; c++) begin
            applyStimulus(c == 8, 1'b0, 3'b010);
            #3;
            checkOutput($sformatf("h_busy_c%0d", c), 8'(busy1), 8'h1);
            checkOutput($sformatf("h_dut_x_c%0d", c), 8'(dut_x1), 8'((c - 1) / 2));
            checkOutput($sformatf("h_done_c%0d", c), 8'(done1), 8'h0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 3'b010);
        #3;
        checkOutput("h_done_c17", 8'(done1), 8'h1);
        checkOutput("h_busy_c17", 8'(busy1), 8'h0);
        checkOutput("h_pass", 8'(pass1), 8'h1);
        checkOutput("h_fail_count", 8'(fail_count1), 8'h0);
        checkOutput("h_ffv", 8'(ffv1), 8'h0);
        checkOutput("h_dut_x_c17", 8'(dut_x1), 8'h2);
        tick();
        #3;
        checkOutput("h_done_c18", 8'(done1), 8'h0);
        checkOutput("h_pass_hold", 8'(pass1), 8'h1);
        tick();

        // Single fault at x == 5
        $display("[TB] fault at x=5");
        bad_tt1 = TRUTH_TABLE ^ 8'b0010_0000;
        applyStimulus(1'b1, 1'b0, 3'b000);
        tick();
        applyStimulus(1'b0, 1'b0, 3'b000);
        #3;
        checkOutput("f5_pass_cleared", 8'(pass1), 8'h0);
        tick();
        for (int c = 2; c <= 16; c++) tick();
        #3;
        checkOutput("f5_done_c17", 8'(done1), 8'h1);
        checkOutput("f5_fail_count", 8'(fail_count1), 8'h1);
        checkOutput("f5_ffvec", 8'(ffvec1), 8'h5);
        checkOutput("f5_ffv", 8'(ffv1), 8'h1);
        checkOutput("f5_pass", 8'(pass1), 8'h0);
        tick(); tick();

        // Stuck-at-1 error, DWELL=1, PASSES=2: saturation
        $display("[TB] stuck-at-1 saturation");
        stuck2 = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            #3;
            checkOutput($sformatf("s_busy_c%0d", c), 8'(busy2), 8'h1);
            checkOutput($sformatf("s_dut_x_c%0d", c), 8'(dut_x2), 8'((c - 1) % 8));
            tick();
        end
        #3;
        checkOutput("s_done_c17", 8'(done2), 8'h1);
        checkOutput("s_fail_count", 8'(fail_count2), 8'hF);
        checkOutput("s_ffvec", 8'(ffvec2), 8'h0);
        checkOutput("s_ffv", 8'(ffv2), 8'h1);
        checkOutput("s_pass", 8'(pass2), 8'h0);
        tick();
        stuck2 = 1'b0;

        // Abort in cycle 6 with a fault at x == 1 already counted
        $display("[TB] abort mid-run");
        bad_tt1 = TRUTH_TABLE ^ 8'b0000_0010;
        applyStimulus(1'b1, 1'b0, 3'b100);
        tick();
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(1'b0, 1'b0, 3'b100);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 3'b100);
        #3;
        checkOutput("a_busy_c6", 8'(busy1), 8'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 3'b100);
        #3;
        checkOutput("a_busy_c7", 8'(busy1), 8'h0);
        checkOutput("a_dut_x_c7", 8'(dut_x1), 8'h4);
        seen_done = 1'b0;
        for (int c = 7; c <= 24; c++) begin
            #1;
            if (done1) seen_done = 1'b1;
            tick();
        end
        checkOutput("a_no_done", 8'(seen_done), 8'h0);
        checkOutput("a_fail_count", 8'(fail_count1), 8'h1);
        checkOutput("a_ffvec", 8'(ffvec1), 8'h1);
        checkOutput("a_pass", 8'(pass1), 8'h0);
        func_x1 = 3'b001;
        #1;
        checkOutput("a_dut_x_track", 8'(dut_x1), 8'h1);
        tick();

        // start and abort together in IDLE
        $display("[TB] start with abort in idle");
        applyStimulus(1'b1, 1'b1, 3'b110);
        #3;
        checkOutput("sa_dut_x_same", 8'(dut_x1), 8'h6);
        tick();
        applyStimulus(1'b0, 1'b0, 3'b110);
        #3;
        checkOutput("sa_busy", 8'(busy1), 8'h0);
        checkOutput("sa_dut_x", 8'(dut_x1), 8'h6);
        checkOutput("sa_fail_kept", 8'(fail_count1), 8'h1);
        tick();

        // Asynchronous reset mid-run with a fault at x == 0 already counted
        $display("[TB] reset mid-run");
        bad_tt1 = TRUTH_TABLE ^ 8'b0000_0001;
        applyStimulus(1'b1, 1'b0, 3'b111);
        tick();
        applyStimulus(1'b0, 1'b0, 3'b111);
        for (int c = 1; c <= 4; c++) tick();
        #1;
        checkOutput("r_fail_before", 8'(fail_count1), 8'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("r_busy", 8'(busy1), 8'h0);
        checkOutput("r_fail_count", 8'(fail_count1), 8'h0);
        checkOutput("r_ffv", 8'(ffv1), 8'h0);
        checkOutput("r_dut_x", 8'(dut_x1), 8'h7);
        tick();
        reset_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (done1 || busy1) seen_done = 1'b1;
            tick();
        end
        checkOutput("r_no_done", 8'(seen_done), 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
